// File: rtl/eth_pkt_loopback_fifo.sv
// Store-and-forward AXIS packet FIFO for the 10G MAC loopback path.
// Frames become visible on TX only once their last beat is written and judged good.
module eth_pkt_loopback_fifo #(
    parameter int DATA_WIDTH = 64,
    parameter int KEEP_WIDTH = DATA_WIDTH / 8,
    parameter int DEPTH_LOG2 = 9,
    parameter int CNT_WIDTH  = 32,
    parameter int DROP_BAD   = 1
) (
    input  logic                  clk156,
    input  logic                  eth_rst_n,

    input  logic                  s_axis_tvalid,
    input  logic [DATA_WIDTH-1:0] s_axis_tdata,
    input  logic [KEEP_WIDTH-1:0] s_axis_tkeep,
    input  logic                  s_axis_tlast,
    input  logic                  s_axis_tuser,

    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic [KEEP_WIDTH-1:0] m_axis_tkeep,
    output logic                  m_axis_tlast,
    output logic                  m_axis_tuser,

    output logic [CNT_WIDTH-1:0]  pkt_cnt,
    output logic [CNT_WIDTH-1:0]  drop_cnt,
    output logic [DEPTH_LOG2:0]   fifo_level,
    output logic                  overflow
);

    localparam int PW     = DEPTH_LOG2 + 1;
    localparam int DEPTH  = 1 << DEPTH_LOG2;
    localparam int WORD_W = DATA_WIDTH + KEEP_WIDTH + 2;

    localparam logic [PW-1:0] PTR_ONE  = PW'(1);
    localparam logic [PW-1:0] PTR_FULL = {1'b1, {DEPTH_LOG2{1'b0}}};

    typedef enum logic [1:0] {
        ST_SYNC,
        ST_IDLE,
        ST_WR,
        ST_DROP
    } wr_state_t;

    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
        return (&v) ? v : v + CNT_WIDTH'(1);
    endfunction

    // Reset is asserted asynchronously but released on a clock edge.
    logic [1:0] rst_sync_reg;
    logic       rst_n;

    always_ff @(posedge clk156 or negedge eth_rst_n) begin
        if (!eth_rst_n) begin
            rst_sync_reg <= 2'b00;
        end else begin
            rst_sync_reg <= {rst_sync_reg[0], 1'b1};
        end
    end

    assign rst_n = rst_sync_reg[1];

    wr_state_t             wr_state_reg;
    logic [PW-1:0]         wr_tmp_reg;
    logic [PW-1:0]         wr_cmt_reg;
    logic [PW-1:0]         rd_reg;
    logic [CNT_WIDTH-1:0]  pkt_cnt_reg;
    logic [CNT_WIDTH-1:0]  drop_cnt_reg;
    logic                  overflow_reg;

    logic                  ram_valid_reg;
    logic [WORD_W-1:0]     ram_q_reg;
    logic                  out_valid_reg;
    logic [WORD_W-1:0]     out_word_reg;

    logic [WORD_W-1:0]     mem [DEPTH];

    // rd_done counts beats actually handed to TX, so prefetched beats still occupy space.
    logic [PW-1:0]         rd_done;
    logic                  full;
    logic                  wr_active;
    logic                  mem_we;
    logic [WORD_W-1:0]     mem_wdata;
    logic                  frame_good;
    logic                  out_ready;
    logic                  rd_empty;
    logic                  rd_en;

    assign rd_done    = rd_reg - {{(PW-1){1'b0}}, ram_valid_reg} - {{(PW-1){1'b0}}, out_valid_reg};
    assign full       = (wr_tmp_reg - rd_done) == PTR_FULL;
    assign wr_active  = (wr_state_reg == ST_IDLE) || (wr_state_reg == ST_WR);
    assign mem_we     = wr_active && s_axis_tvalid && !full;
    assign mem_wdata  = {s_axis_tlast & ~s_axis_tuser, s_axis_tlast, s_axis_tkeep, s_axis_tdata};
    assign frame_good = s_axis_tuser || (DROP_BAD == 0);

    assign out_ready  = !out_valid_reg || m_axis_tready;
    assign rd_empty   = (rd_reg == wr_cmt_reg);
    assign rd_en      = !rd_empty && (!ram_valid_reg || out_ready);

    always_ff @(posedge clk156) begin
        if (mem_we) begin
            mem[wr_tmp_reg[DEPTH_LOG2-1:0]] <= mem_wdata;
        end
        if (rd_en) begin
            ram_q_reg <= mem[rd_reg[DEPTH_LOG2-1:0]];
        end
    end

    always_ff @(posedge clk156 or negedge rst_n) begin
        if (!rst_n) begin
            wr_state_reg <= ST_SYNC;
            wr_tmp_reg   <= '0;
            wr_cmt_reg   <= '0;
            pkt_cnt_reg  <= '0;
            drop_cnt_reg <= '0;
            overflow_reg <= 1'b0;
        end else begin
            case (wr_state_reg)
                // Wait for a gap so a frame cut by reset is never taken from its middle.
                ST_SYNC: begin
                    if (!s_axis_tvalid) begin
                        wr_state_reg <= ST_IDLE;
                    end
                end
                ST_IDLE, ST_WR: begin
                    if (s_axis_tvalid) begin
                        if (!full) begin
                            if (s_axis_tlast) begin
                                wr_state_reg <= ST_IDLE;
                                if (frame_good) begin
                                    wr_tmp_reg  <= wr_tmp_reg + PTR_ONE;
                                    wr_cmt_reg  <= wr_tmp_reg + PTR_ONE;
                                    pkt_cnt_reg <= sat_inc(pkt_cnt_reg);
                                end else begin
                                    wr_tmp_reg   <= wr_cmt_reg;
                                    drop_cnt_reg <= sat_inc(drop_cnt_reg);
                                end
                            end else begin
                                wr_tmp_reg   <= wr_tmp_reg + PTR_ONE;
                                wr_state_reg <= ST_WR;
                            end
                        end else begin
                            wr_tmp_reg <= wr_cmt_reg;
                            if (s_axis_tlast) begin
                                wr_state_reg <= ST_IDLE;
                                drop_cnt_reg <= sat_inc(drop_cnt_reg);
                                overflow_reg <= 1'b1;
                            end else begin
                                wr_state_reg <= ST_DROP;
                            end
                        end
                    end
                end
                ST_DROP: begin
                    if (s_axis_tvalid && s_axis_tlast) begin
                        wr_state_reg <= ST_IDLE;
                        drop_cnt_reg <= sat_inc(drop_cnt_reg);
                        overflow_reg <= 1'b1;
                    end
                end
                default: begin
                    wr_state_reg <= ST_SYNC;
                end
            endcase
        end
    end

    // Two-stage read pipe: RAM output register feeds the TX output register.
    always_ff @(posedge clk156 or negedge rst_n) begin
        if (!rst_n) begin
            rd_reg        <= '0;
            ram_valid_reg <= 1'b0;
            out_valid_reg <= 1'b0;
            out_word_reg  <= '0;
        end else begin
            if (rd_en) begin
                rd_reg        <= rd_reg + PTR_ONE;
                ram_valid_reg <= 1'b1;
            end else if (out_ready) begin
                ram_valid_reg <= 1'b0;
            end
            if (out_ready) begin
                out_valid_reg <= ram_valid_reg;
                if (ram_valid_reg) begin
                    out_word_reg <= ram_q_reg;
                end
            end
        end
    end

    assign m_axis_tvalid = out_valid_reg;
    assign m_axis_tdata  = out_word_reg[DATA_WIDTH-1:0];
    assign m_axis_tkeep  = out_word_reg[DATA_WIDTH +: KEEP_WIDTH];
    assign m_axis_tlast  = out_word_reg[WORD_W-2];
    assign m_axis_tuser  = out_word_reg[WORD_W-1];

    assign pkt_cnt    = pkt_cnt_reg;
    assign drop_cnt   = drop_cnt_reg;
    assign overflow   = overflow_reg;
    assign fifo_level = wr_cmt_reg - rd_done;

endmodule

// File: tb/tb_eth_pkt_loopback_fifo.sv
// Bench for eth_pkt_loopback_fifo: two instances (drop-bad and forward-bad) on shared RX stimulus,
// checked beat by beat against a frame-level scoreboard.
module tb_eth_pkt_loopback_fifo;

    localparam int DW    = 64;
    localparam int KW    = 8;
    localparam int DL    = 4;
    localparam int CW    = 32;
    localparam int DEPTH = 1 << DL;
    localparam int LIMIT = 600;

    typedef logic [DW+KW+1:0] word_t;

    logic          clk156 = 1'b0;
    logic          eth_rst_n;
    logic          s_tvalid;
    logic [DW-1:0] s_tdata;
    logic [KW-1:0] s_tkeep;
    logic          s_tlast;
    logic          s_tuser;
    logic          m_tready;

    logic          m_tvalid   [2];
    logic [DW-1:0] m_tdata    [2];
    logic [KW-1:0] m_tkeep    [2];
    logic          m_tlast    [2];
    logic          m_tuser    [2];
    logic [CW-1:0] pkt_cnt    [2];
    logic [CW-1:0] drop_cnt   [2];
    logic [DL:0]   fifo_level [2];
    logic          overflow   [2];

    always #5 clk156 = ~clk156;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_dut
            eth_pkt_loopback_fifo #(
                .DATA_WIDTH (DW),
                .KEEP_WIDTH (KW),
                .DEPTH_LOG2 (DL),
                .CNT_WIDTH  (CW),
                .DROP_BAD   ((gi == 0) ? 1 : 0)
            ) u_dut (
                .clk156        (clk156),
                .eth_rst_n     (eth_rst_n),
                .s_axis_tvalid (s_tvalid),
                .s_axis_tdata  (s_tdata),
                .s_axis_tkeep  (s_tkeep),
                .s_axis_tlast  (s_tlast),
                .s_axis_tuser  (s_tuser),
                .m_axis_tvalid (m_tvalid[gi]),
                .m_axis_tready (m_tready),
                .m_axis_tdata  (m_tdata[gi]),
                .m_axis_tkeep  (m_tkeep[gi]),
                .m_axis_tlast  (m_tlast[gi]),
                .m_axis_tuser  (m_tuser[gi]),
                .pkt_cnt       (pkt_cnt[gi]),
                .drop_cnt      (drop_cnt[gi]),
                .fifo_level    (fifo_level[gi]),
                .overflow      (overflow[gi])
            );
        end
    endgenerate

    // Reference model: expected TX beats and counters per instance (0 drops bad, 1 forwards bad).
    word_t exp_q [2][$];
    int    exp_pkt  [2];
    int    exp_drop [2];
    bit    exp_ovf  [2];
    int    n_vec = 0;
    int    n_err = 0;
    int    tready_mode = 0;

    task automatic check(input string tag, input logic [95:0] got, input logic [95:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk156);
        #1;
    endtask

    task automatic clear_model();
        for (int i = 0; i < 2; i++) begin
            exp_q[i].delete();
            exp_pkt[i]  = 0;
            exp_drop[i] = 0;
            exp_ovf[i]  = 1'b0;
        end
    endtask

    // 0: ready high, 1: ready low, 2: toggle every cycle, 3: random
    initial begin
        m_tready = 1'b1;
        forever begin
            @(posedge clk156);
            #1;
            case (tready_mode)
                0:       m_tready = 1'b1;
                1:       m_tready = 1'b0;
                2:       m_tready = ~m_tready;
                default: m_tready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    always @(negedge clk156) begin
        if (eth_rst_n) begin
            for (int i = 0; i < 2; i++) begin
                if (m_tvalid[i]) begin
                    if (exp_q[i].size() == 0) begin
                        check($sformatf("spurious_beat%0d", i), 96'(m_tvalid[i]), 96'd0);
                    end else begin
                        check($sformatf("tx_beat%0d", i),
                              96'({m_tuser[i], m_tlast[i], m_tkeep[i], m_tdata[i]}), 96'(exp_q[i][0]));
                        if (m_tready) begin
                            exp_q[i].delete(0);
                        end
                    end
                end
            end
        end
    end

    // A frame fits when its length does not exceed the space left by committed, unsent beats.
    task automatic send_frame(input int len, input bit good, input int gap);
        bit    fits [2];
        bit    good_i;
        word_t beats [$];
        for (int i = 0; i < 2; i++) begin
            fits[i] = (len <= DEPTH - exp_q[i].size());
        end
        for (int b = 0; b < len; b++) begin
            s_tvalid = 1'b1;
            s_tdata  = {$urandom, $urandom};
            s_tlast  = (b == len - 1);
            s_tkeep  = s_tlast ? 8'($urandom_range(1, 255)) : 8'hff;
            s_tuser  = s_tlast ? good : 1'($urandom_range(0, 1));
            beats.push_back({1'b0, s_tlast, s_tkeep, s_tdata});
            if (s_tlast) begin
                for (int i = 0; i < 2; i++) begin
                    good_i = good || (i == 1);
                    if (!fits[i]) begin
                        exp_drop[i]++;
                        exp_ovf[i] = 1'b1;
                    end else if (good_i) begin
                        exp_pkt[i]++;
                        for (int k = 0; k < len; k++) begin
                            exp_q[i].push_back({(k == len - 1) && !good, beats[k][DW+KW:0]});
                        end
                    end else begin
                        exp_drop[i]++;
                    end
                end
            end
            tick();
        end
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
        repeat (gap) tick();
    endtask

    task automatic drive_raw(input bit last, input bit user);
        s_tvalid = 1'b1;
        s_tdata  = {$urandom, $urandom};
        s_tkeep  = 8'hff;
        s_tlast  = last;
        s_tuser  = user;
        tick();
    endtask

    task automatic wait_room(input int len);
        int t = 0;
        while ((exp_q[0].size() + len > DEPTH || exp_q[1].size() + len > DEPTH) && t < LIMIT) begin
            tick();
            t++;
        end
        check("room_wait_expired", 96'(t >= LIMIT), 96'd0);
    endtask

    task automatic checkpoint(input string name);
        int t = 0;
        tready_mode = 0;
        while ((exp_q[0].size() != 0 || exp_q[1].size() != 0) && t < LIMIT) begin
            tick();
            t++;
        end
        repeat (4) tick();
        for (int i = 0; i < 2; i++) begin
            check($sformatf("%s_undelivered%0d", name, i), 96'(exp_q[i].size()), 96'd0);
            check($sformatf("%s_tvalid%0d", name, i), 96'(m_tvalid[i]), 96'd0);
            check($sformatf("%s_pkt_cnt%0d", name, i), 96'(pkt_cnt[i]), 96'(exp_pkt[i]));
            check($sformatf("%s_drop_cnt%0d", name, i), 96'(drop_cnt[i]), 96'(exp_drop[i]));
            check($sformatf("%s_overflow%0d", name, i), 96'(overflow[i]), 96'(exp_ovf[i]));
            check($sformatf("%s_level%0d", name, i), 96'(fifo_level[i]), 96'd0);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        eth_rst_n = 1'b0;
        s_tvalid  = 1'b0;
        s_tdata   = '0;
        s_tkeep   = '0;
        s_tlast   = 1'b0;
        s_tuser   = 1'b0;
        clear_model();
        repeat (4) tick();
        eth_rst_n = 1'b1;
        repeat (3) tick();
        for (int i = 0; i < 2; i++) begin
            check($sformatf("rst_tvalid%0d", i), 96'(m_tvalid[i]), 96'd0);
            check($sformatf("rst_tdata%0d", i), 96'(m_tdata[i]), 96'd0);
            check($sformatf("rst_pkt_cnt%0d", i), 96'(pkt_cnt[i]), 96'd0);
            check($sformatf("rst_drop_cnt%0d", i), 96'(drop_cnt[i]), 96'd0);
            check($sformatf("rst_level%0d", i), 96'(fifo_level[i]), 96'd0);
            check($sformatf("rst_overflow%0d", i), 96'(overflow[i]), 96'd0);
        end

        // 8-beat good frame
        tick();
        send_frame(8, 1'b1, 1);
        checkpoint("t1");

        // bad frame then good frame
        send_frame(4, 1'b0, 1);
        send_frame(3, 1'b1, 1);
        checkpoint("t2");

        // overflow with TX stalled: second 10-beat frame cannot fit
        tready_mode = 1;
        tick();
        send_frame(10, 1'b1, 1);
        send_frame(10, 1'b1, 2);
        repeat (3) tick();
        for (int i = 0; i < 2; i++) begin
            check($sformatf("t3_stall_level%0d", i), 96'(fifo_level[i]), 96'(exp_q[i].size()));
            check($sformatf("t3_stall_overflow%0d", i), 96'(overflow[i]), 96'(exp_ovf[i]));
        end
        checkpoint("t3");

        // exactly DEPTH beats fit, DEPTH+1 do not
        tready_mode = 1;
        tick();
        send_frame(DEPTH, 1'b1, 3);
        for (int i = 0; i < 2; i++) begin
            check($sformatf("t3_full_level%0d", i), 96'(fifo_level[i]), 96'(exp_q[i].size()));
        end
        checkpoint("t3_full");
        tready_mode = 1;
        tick();
        send_frame(DEPTH + 1, 1'b1, 3);
        for (int i = 0; i < 2; i++) begin
            check($sformatf("t3_over_level%0d", i), 96'(fifo_level[i]), 96'(exp_q[i].size()));
        end
        checkpoint("t3_over");

        // reset in the middle of a frame, released while the frame continues
        repeat (3) drive_raw(1'b0, 1'b0);
        eth_rst_n = 1'b0;
        clear_model();
        repeat (2) drive_raw(1'b0, 1'b0);
        eth_rst_n = 1'b1;
        repeat (4) drive_raw(1'b0, 1'b0);
        drive_raw(1'b1, 1'b1);
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
        repeat (3) tick();
        checkpoint("t4_rst");
        send_frame(5, 1'b1, 1);
        checkpoint("t4");

        // back-to-back single-beat frames against a toggling ready
        tready_mode = 2;
        for (int f = 0; f < 12; f++) begin
            send_frame(1, 1'b1, 0);
        end
        repeat (2) tick();
        checkpoint("t5");

        // bad 2-beat frame: forwarded with error flag by instance 1, dropped by instance 0
        send_frame(2, 1'b0, 1);
        checkpoint("t6");

        // randomized frames, lengths, gaps and ready
        tready_mode = 3;
        for (int f = 0; f < 40; f++) begin
            int  len;
            bit  good;
            len  = $urandom_range(1, 6);
            good = ($urandom_range(0, 4) != 0);
            wait_room(len);
            send_frame(len, good, $urandom_range(0, 2));
        end
        checkpoint("rand");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
